// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, feeds a 2-entry
// instruction queue to decode, handles redirects and fetch faults.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   imem_addr      word index to instruction memory (fetch_pc >> 2)
//   imem_instr     combinational read data for imem_addr
//   redirect_valid load redirect_pc this cycle, flushing the queue
//   redirect_pc    byte address of the new fetch target
//   inst_valid     queue head valid
//   inst_ready     decode accepts the head this cycle
//   inst_out       queue head instruction (holds when not valid)
//   inst_pc        byte address of inst_out (holds when not valid)
//   fault          sticky fetch fault (misaligned or out of range)
//   queue_count    entries held, 0..2
module fetch_sequencer #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic        fault,
  output logic [1:0]  queue_count
);

  typedef enum logic {
    RUN,
    FAULT
  } state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [31:0] q_instr [2];
  logic [63:0] q_pc    [2];
  logic [1:0]  count;
  logic        fault_q;

  logic pop;
  logic space;
  logic attempt;
  logic bad;
  logic push;

  assign imem_addr = fetch_pc >> 2;

  assign pop     = (count != 2'd0) && inst_ready && !redirect_valid;
  // A pop frees the tail slot in the same cycle, so a full queue
  // can still accept a new word and keep one instruction per cycle.
  assign space   = (count != 2'd2) || pop;
  assign attempt = (state == RUN) && !redirect_valid && space;
  assign bad     = (fetch_pc[1:0] != 2'b00) ||
                   (imem_addr >= 64'(DEPTH));
  assign push    = attempt && !bad;

  assign inst_valid  = (count != 2'd0);
  assign inst_out    = q_instr[0];
  assign inst_pc     = q_pc[0];
  assign fault       = fault_q;
  assign queue_count = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      fault_q    <= 1'b0;
      fetch_pc   <= RESET_PC;
      count      <= 2'd0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
    end else if (redirect_valid) begin
      // Entries are dropped but q[0] is kept so the head outputs hold.
      state    <= RUN;
      fault_q  <= 1'b0;
      fetch_pc <= redirect_pc;
      count    <= 2'd0;
    end else begin
      if (attempt && bad) begin
        state   <= FAULT;
        fault_q <= 1'b1;
      end
      if (push) begin
        fetch_pc <= fetch_pc + 64'd4;
      end
      unique case (1'b1)
        (push && pop): begin
          if (count == 2'd2) begin
            q_instr[0] <= q_instr[1];
            q_pc[0]    <= q_pc[1];
            q_instr[1] <= imem_instr;
            q_pc[1]    <= fetch_pc;
          end else begin
            q_instr[0] <= imem_instr;
            q_pc[0]    <= fetch_pc;
          end
        end
        (pop && !push): begin
          if (count == 2'd2) begin
            q_instr[0] <= q_instr[1];
            q_pc[0]    <= q_pc[1];
          end
          count <= count - 2'd1;
        end
        (push && !pop): begin
          if (count == 2'd0) begin
            q_instr[0] <= imem_instr;
            q_pc[0]    <= fetch_pc;
          end else begin
            q_instr[1] <= imem_instr;
            q_pc[1]    <= fetch_pc;
          end
          count <= count + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer (DEPTH = 4): directed vector table plus
// randomized traffic checked against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;

  localparam logic [31:0] I0 = 32'h8B1F03E5;
  localparam logic [31:0] I1 = 32'hF84000A4;
  localparam logic [31:0] I2 = 32'h8B040086;
  localparam logic [31:0] I3 = 32'hF80010A6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        fault;
  logic [1:0]  queue_count;

  logic [31:0] mem [8];

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 64'd8) ? mem[imem_addr[2:0]]
                                          : 32'hDEADBEEF;

  fetch_sequencer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .fault(fault),
    .queue_count(queue_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit v,
                         input int unsigned cnt, input logic [31:0] o,
                         input logic [63:0] p, input bit f,
                         input logic [63:0] a);
    chk({tag, ".inst_valid"}, 64'(inst_valid), 64'(v));
    chk({tag, ".queue_count"}, 64'(queue_count), 64'(cnt));
    chk({tag, ".inst_out"}, 64'(inst_out), 64'(o));
    chk({tag, ".inst_pc"}, inst_pc, p);
    chk({tag, ".fault"}, 64'(fault), 64'(f));
    chk({tag, ".imem_addr"}, imem_addr, a);
  endtask

  // Reference model: a plain FIFO of fetched words plus a PC and a
  // fault flag, advanced by the behavioural fetch rules.
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t        mq [$];
  logic [63:0] mpc;
  bit          mfault;
  ent_t        hold;

  task automatic model_step();
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      mpc    = RPC;
      mfault = 0;
      hold   = '{32'h0, 64'h0};
    end else if (redirect_valid) begin
      mq.delete();
      mpc    = redirect_pc;
      mfault = 0;
    end else begin
      if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
      if (!mfault && mq.size() < 2) begin
        if (mpc[1:0] != 2'b00 || (mpc / 4) >= 64'(DEPTH)) begin
          mfault = 1;
        end else begin
          e.instr = mem[mpc[4:2]];
          e.pc    = mpc;
          mq.push_back(e);
          mpc = mpc + 64'd4;
        end
      end
    end
    if (mq.size() > 0) hold = mq[0];
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    bit          rst;
    bit          rd;
    logic [63:0] rpc;
    bit          rdy;
    bit          v;
    int unsigned cnt;
    logic [31:0] o;
    logic [63:0] p;
    bit          f;
    logic [63:0] a;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t r(bit rst, bit rd, logic [63:0] rpc, bit rdy,
                             bit v, int unsigned cnt, logic [31:0] o,
                             logic [63:0] p, bit f, logic [63:0] a);
    vec_t x;
    x = '{rst, rd, rpc, rdy, v, cnt, o, p, f, a};
    return x;
  endfunction

  initial begin
    mem[0] = I0;
    mem[1] = I1;
    mem[2] = I2;
    mem[3] = I3;
    mem[4] = 32'h11111111;
    mem[5] = 32'h22222222;
    mem[6] = 32'h33333333;
    mem[7] = 32'h44444444;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // stream, fault at end of memory, redirect recovery
    vecs.push_back(r(0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(r(1,0,0,1, 1,1,I0,0,0,1));
    vecs.push_back(r(1,0,0,1, 1,1,I1,4,0,2));
    vecs.push_back(r(1,0,0,1, 1,1,I2,8,0,3));
    vecs.push_back(r(1,0,0,1, 1,1,I3,'hC,0,4));
    vecs.push_back(r(1,0,0,1, 0,0,I3,'hC,1,4));
    vecs.push_back(r(1,0,0,1, 0,0,I3,'hC,1,4));
    vecs.push_back(r(1,1,0,1, 0,0,I3,'hC,0,0));
    vecs.push_back(r(1,0,0,1, 1,1,I0,0,0,1));
    // fill, redirect to 8 from a full queue
    vecs.push_back(r(1,0,0,0, 1,2,I0,0,0,2));
    vecs.push_back(r(1,0,0,0, 1,2,I0,0,0,2));
    vecs.push_back(r(1,1,8,0, 0,0,I0,0,0,2));
    vecs.push_back(r(1,0,0,0, 1,1,I2,8,0,3));
    vecs.push_back(r(1,0,0,0, 1,2,I2,8,0,4));
    vecs.push_back(r(1,0,0,0, 1,2,I2,8,0,4));
    vecs.push_back(r(1,0,0,1, 1,1,I3,'hC,1,4));
    vecs.push_back(r(1,0,0,1, 0,0,I3,'hC,1,4));
    // misaligned redirect, then recovery to 4
    vecs.push_back(r(1,1,6,1, 0,0,I3,'hC,0,1));
    vecs.push_back(r(1,0,0,1, 0,0,I3,'hC,1,1));
    vecs.push_back(r(1,1,4,1, 0,0,I3,'hC,0,1));
    vecs.push_back(r(1,0,0,1, 1,1,I1,4,0,2));
    vecs.push_back(r(1,0,0,0, 1,2,I1,4,0,3));
    // reset with a full queue
    vecs.push_back(r(0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(r(1,0,0,1, 1,1,I0,0,0,1));
    // redirect discards a head that decode was accepting
    vecs.push_back(r(1,1,0,1, 0,0,I0,0,0,0));
    vecs.push_back(r(1,0,0,1, 1,1,I0,0,0,1));
    // stall from reset, then no-bubble drain
    vecs.push_back(r(0,0,0,1, 0,0,0,0,0,0));
    vecs.push_back(r(1,0,0,0, 1,1,I0,0,0,1));
    vecs.push_back(r(1,0,0,0, 1,2,I0,0,0,2));
    vecs.push_back(r(1,0,0,0, 1,2,I0,0,0,2));
    vecs.push_back(r(1,0,0,1, 1,2,I1,4,0,3));
    vecs.push_back(r(1,0,0,1, 1,2,I2,8,0,4));
    vecs.push_back(r(1,0,0,1, 1,1,I3,'hC,1,4));
    vecs.push_back(r(1,0,0,1, 0,0,I3,'hC,1,4));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_n          = vecs[i].rst;
      redirect_valid = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      inst_ready     = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].cnt,
              vecs[i].o, vecs[i].p, vecs[i].f, vecs[i].a);
    end

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    step();
    for (int c = 0; c < 3000; c++) begin
      int unsigned k;
      rst_n          = ($urandom_range(0, 63) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 15);
      if (k < 12)
        redirect_pc = 64'(k % 6) * 64'd4;
      else if (k < 14)
        redirect_pc = 64'($urandom_range(0, 7)) * 64'd4 +
                      64'($urandom_range(1, 3));
      else if (k == 14)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      else
        redirect_pc = 64'h0000_0001_0000_0000;
      step();
      chk_all($sformatf("rnd%0d", c), mq.size() > 0, mq.size(),
              hold.instr, hold.pc, mfault, mpc >> 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the word-indexed instruction memory and the decode stage. Owns the fetch PC, drives the memory's combinational read address, buffers fetched words in a 2-entry queue with a valid/ready handshake toward decode, and handles branch redirects and out-of-range fetch faults. Replaces direct PC-to-memory wiring in the single-cycle datapath so decode can stall without losing instructions.

## Interface

- DEPTH, 256: instruction memory size in 32-bit words.
- RESET_PC, 64'h0: byte address fetched first after reset.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- imem_addr  output  64  word index to memory; always equals fetch_pc >> 2.
- imem_instr  input  32  combinational read data for imem_addr.
- redirect_valid  input  1  load redirect_pc this cycle (branch/exception).
- redirect_pc  input  64  byte address of new fetch target.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode accepts head this cycle.
- inst_out  output  32  queue head instruction.
- inst_pc  output  64  byte address of inst_out.
- fault  output  1  sticky fetch fault (misaligned or word index >= DEPTH).
- queue_count  output  2  entries held (0..2).

## Operation

- States: RUN, FAULT. Reset enters RUN with fetch_pc = RESET_PC.
- Pop: inst_valid && inst_ready && !redirect_valid; head removed, second entry (if any) becomes head.
- Push (RUN only): when queue_count < 2 or a pop occurs this cycle; captures {imem_instr, fetch_pc} into the tail, fetch_pc += 4. Simultaneous push+pop at count 2 keeps count 2.
- Fault check precedes push: if fetch_pc[1:0] != 0 or (fetch_pc >> 2) >= DEPTH, no push, fault <= 1, state <= FAULT, fetch_pc holds.
- FAULT: no pushes; pops continue so queue drains; fault stays 1.
- Redirect (highest priority, any state): queue flushed (count 0), head presented this cycle discarded regardless of inst_ready, fetch_pc <= redirect_pc, no push this cycle, fault <= 0, state <= RUN. Fault check applies to the new PC on the next cycle.
- fetch_pc wraps modulo 2^64 (only reachable with DEPTH near 2^62; no special handling).
- inst_out/inst_pc hold last value when inst_valid = 0.

## Timing

- Reset values: inst_valid 0, inst_out 0, inst_pc 0, fault 0, queue_count 0, imem_addr RESET_PC >> 2, state RUN.
- rst_n sampled only at clk edge; asserting mid-operation discards queue and fault on that edge.
- Fetch-to-valid latency 1 cycle: word pushed at edge N appears on inst_out after edge N if queue was empty.
- Sustained throughput 1 instruction/cycle with inst_ready held high; no bubble when ready rises after a stall with count 2.
- Redirect at edge N: inst_valid 0 after edge N; target instruction valid after edge N+1 (2-cycle redirect penalty).
- Fault raised at edge of the failed push attempt; visible immediately after.

## Test plan

- Memory words 0..3 = 8B1F03E5, F84000A4, 8B040086, F80010A6; release reset, inst_ready = 1 -> one instruction per cycle from first cycle after reset: (8B1F03E5, pc 0), (F84000A4, 4), (8B040086, 8), (F80010A6, 0xC).
- inst_ready = 0 from reset -> queue_count 1 then 2, imem_addr holds 2, head stays 8B1F03E5; raise inst_ready -> four instructions on consecutive cycles, no bubble.
- With queue_count 2, redirect_valid = 1, redirect_pc = 0x8 -> next cycle queue_count 0, inst_valid 0; following cycle inst_out 8B040086, inst_pc 8.
- DEPTH = 4, inst_ready = 1 -> after pc 0xC delivered, fault = 1, imem_addr holds 4, inst_valid 0 once drained; redirect to 0x0 clears fault, 8B1F03E5 reappears 2 cycles later.
- Redirect to 0x6 -> cycle after redirect fault = 1, no push, inst_valid 0; redirect to 0x4 -> fault 0, F84000A4 delivered.
- rst_n low one cycle with queue_count 2 and fault 0 -> all outputs at reset values after that edge; restart delivers 8B1F03E5 first.
